// File: rtl/PKG_pwm.sv
// Shared types and defaults for the CPWM carrier time-base.
package PKG_pwm;

  localparam int DEF_DIVCLK_WIDTH   = 5;
  localparam int DEF_PWMCOUNT_WIDTH = 16;
  localparam int DEF_INTCOUNT_WIDTH = 3;

  typedef enum logic { PWM_OFF = 1'b0, PWM_ON = 1'b1 } _pwm_onoff;
  typedef enum logic { INT_OFF = 1'b0, INT_ON = 1'b1 } _int_onoff;

  typedef enum logic [1:0] {
    COUNT_UP     = 2'd0,
    COUNT_DOWN   = 2'd1,
    COUNT_UPDOWN = 2'd2
  } _count_mode;

  typedef enum logic [1:0] {
    NO_MASK     = 2'd0,
    MIN_MASK    = 2'd1,
    MAX_MASK    = 2'd2,
    MINMAX_MASK = 2'd3
  } _mask_mode;

  // Which carrier events survive the mask and trigger reload/irq.
  function automatic logic qualify(_mask_mode m, logic mn, logic mx);
    case (m)
      NO_MASK:  return mn | mx;
      MIN_MASK: return mx;
      MAX_MASK: return mn;
      default:  return 1'b0;
    endcase
  endfunction

  // Direction a (re)configured mode starts in from the current position.
  function automatic logic mode_dir(_count_mode m, logic at_zero);
    case (m)
      COUNT_DOWN:   return 1'b1;
      COUNT_UPDOWN: return !at_zero;
      default:      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pwm_carrier_counter_prescaler.sv
// Clock divider: tick every div+1 enabled cycles; clr parks the count at 0.
module pwm_prescaler #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic [W-1:0] div,
  output logic         tick
);

  logic [W-1:0] cnt;

  // >= keeps a shrunken divide value from skipping a whole wrap.
  assign tick = !clr && (cnt >= div);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)             cnt <= '0;
    else if (clr || tick)  cnt <= '0;
    else                   cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/pwm_carrier_counter.sv
// CPWM carrier: prescaled up/down/up-down counter with shadowed config,
// min/max events, masked shadow reload and decimated interrupt.
module pwm_carrier_counter
  import PKG_pwm::*;
#(
  parameter int DIVCLK_WIDTH   = DEF_DIVCLK_WIDTH,
  parameter int PWMCOUNT_WIDTH = DEF_PWMCOUNT_WIDTH,
  parameter int INTCOUNT_WIDTH = DEF_INTCOUNT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  _pwm_onoff                 pwm_onoff,
  input  _count_mode                count_mode,
  input  _mask_mode                 mask_mode,
  input  _int_onoff                 int_onoff,
  input  logic [DIVCLK_WIDTH-1:0]   div_clk,
  input  logic [PWMCOUNT_WIDTH-1:0] period,
  input  logic [PWMCOUNT_WIDTH-1:0] init_carrier,
  input  logic [INTCOUNT_WIDTH-1:0] int_count,
  output logic [PWMCOUNT_WIDTH-1:0] carrier,
  output logic                      dir_down,
  output logic                      step,
  output logic                      min_evt,
  output logic                      max_evt,
  output logic                      load_evt,
  output logic                      irq
);

  localparam int PW = PWMCOUNT_WIDTH;
  localparam int DW = DIVCLK_WIDTH;
  localparam int IW = INTCOUNT_WIDTH;

  logic [PW-1:0] p_sh;
  logic [DW-1:0] div_sh;
  _count_mode    mode_sh;
  _mask_mode     mask_sh;
  logic [IW-1:0] int_cnt;

  logic          run;
  logic          tick;
  logic [PW-1:0] p_eff;
  logic [DW-1:0] div_eff;
  _count_mode    mode_eff;
  logic          dir_eff;
  logic [PW-1:0] nxt_carrier;
  logic          nxt_dir;
  logic [PW-1:0] init_clamp;
  logic          off_dir;

  assign run = (pwm_onoff == PWM_ON);

  assign min_evt  = step && (carrier == '0);
  assign max_evt  = step && (carrier == p_sh) && (p_sh != '0);
  assign load_evt = qualify(mask_sh, min_evt, max_evt);

  // On a load edge the fresh inputs already govern this edge's step.
  assign p_eff    = load_evt ? period     : p_sh;
  assign div_eff  = load_evt ? div_clk    : div_sh;
  assign mode_eff = load_evt ? count_mode : mode_sh;
  assign dir_eff  = load_evt ? mode_dir(count_mode, carrier == '0) : dir_down;

  assign init_clamp = (init_carrier > period) ? period : init_carrier;

  always_comb begin
    off_dir = 1'b0;
    case (count_mode)
      COUNT_DOWN:   off_dir = 1'b1;
      COUNT_UPDOWN: off_dir = (init_carrier >= period);
      default:      off_dir = 1'b0;
    endcase
  end

  pwm_prescaler #(.W(DW)) u_presc (
    .clk  (clk),
    .rstn (rstn),
    .clr  (!run),
    .div  (div_eff),
    .tick (tick)
  );

  always_comb begin
    nxt_carrier = carrier;
    nxt_dir     = dir_eff;
    case (mode_eff)
      COUNT_DOWN: begin
        nxt_carrier = (carrier == '0) ? p_eff : carrier - PW'(1);
        nxt_dir     = 1'b1;
      end
      COUNT_UPDOWN: begin
        if (p_eff == '0)  nxt_carrier = '0;
        else if (dir_eff) nxt_carrier = carrier - PW'(1);
        else              nxt_carrier = carrier + PW'(1);
        // Turn around at the endpoints; above-top (after a shrink) keeps descending.
        if (nxt_carrier == '0)         nxt_dir = 1'b0;
        else if (nxt_carrier >= p_eff) nxt_dir = 1'b1;
      end
      default: begin
        nxt_carrier = (carrier >= p_eff) ? '0 : carrier + PW'(1);
        nxt_dir     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      carrier  <= '0;
      dir_down <= 1'b0;
      step     <= 1'b0;
      p_sh     <= '0;
      div_sh   <= '0;
      mode_sh  <= COUNT_UP;
      mask_sh  <= NO_MASK;
    end else if (!run) begin
      carrier  <= init_clamp;
      dir_down <= off_dir;
      step     <= 1'b0;
      p_sh     <= period;
      div_sh   <= div_clk;
      mode_sh  <= count_mode;
      mask_sh  <= mask_mode;
    end else begin
      step <= tick;
      if (load_evt) begin
        p_sh    <= period;
        div_sh  <= div_clk;
        mode_sh <= count_mode;
        mask_sh <= mask_mode;
      end
      if (tick) begin
        carrier  <= nxt_carrier;
        dir_down <= nxt_dir;
      end else begin
        dir_down <= dir_eff;
      end
    end
  end

  // Decimator compares against the live int_count; overshoot wraps the counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      int_cnt <= '0;
      irq     <= 1'b0;
    end else if (!run || (int_onoff == INT_OFF)) begin
      int_cnt <= '0;
      irq     <= 1'b0;
    end else begin
      irq <= load_evt && (int_cnt == int_count);
      if (load_evt)
        int_cnt <= (int_cnt == int_count) ? '0 : int_cnt + IW'(1);
    end
  end

endmodule

// File: tb/tb_pwm_carrier_counter.sv
// Bench for pwm_carrier_counter: directed table, corner sequences, random vs model.
module tb_pwm_carrier_counter;
  import PKG_pwm::*;

  localparam int DW = 5, PW = 16, IW = 3;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  _pwm_onoff     pwm_onoff = PWM_OFF;
  _count_mode    count_mode = COUNT_UP;
  _mask_mode     mask_mode = NO_MASK;
  _int_onoff     int_onoff = INT_OFF;
  logic [DW-1:0] div_clk = '0;
  logic [PW-1:0] period = '0;
  logic [PW-1:0] init_carrier = '0;
  logic [IW-1:0] int_count = '0;
  logic [PW-1:0] carrier;
  logic dir_down, step, min_evt, max_evt, load_evt, irq;

  pwm_carrier_counter #(.DIVCLK_WIDTH(DW), .PWMCOUNT_WIDTH(PW), .INTCOUNT_WIDTH(IW)) dut (
    .clk(clk), .rstn(rstn), .pwm_onoff(pwm_onoff), .count_mode(count_mode),
    .mask_mode(mask_mode), .int_onoff(int_onoff), .div_clk(div_clk), .period(period),
    .init_carrier(init_carrier), .int_count(int_count), .carrier(carrier),
    .dir_down(dir_down), .step(step), .min_evt(min_evt), .max_evt(max_evt),
    .load_evt(load_evt), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  // Reference: position/direction walk, countdown to next step, loads counted mod 2^IW.
  int m_pos, m_wait, m_P, m_div, m_mode, m_mask, m_ecnt;
  bit m_down, m_fresh, m_irq;

  function automatic bit m_min(); return m_fresh && m_pos == 0; endfunction
  function automatic bit m_max(); return m_fresh && m_P != 0 && m_pos == m_P; endfunction
  function automatic bit m_load();
    case (m_mask)
      0: return m_min() || m_max();
      1: return m_max();
      2: return m_min();
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_pos = 0; m_wait = 0; m_P = 0; m_div = 0; m_mode = 0; m_mask = 0; m_ecnt = 0;
    m_down = 0; m_fresh = 0; m_irq = 0;
  endtask

  task automatic model_edge();
    bit ld;
    if (pwm_onoff == PWM_OFF) begin
      m_pos  = (int'(init_carrier) > int'(period)) ? int'(period) : int'(init_carrier);
      m_down = (count_mode == COUNT_UP) ? 1'b0 : (count_mode == COUNT_DOWN) ? 1'b1 :
               (int'(init_carrier) >= int'(period));
      m_fresh = 0; m_wait = int'(div_clk);
      m_P = int'(period); m_div = int'(div_clk); m_mode = int'(count_mode); m_mask = int'(mask_mode);
      m_ecnt = 0; m_irq = 0;
      return;
    end
    ld = m_load();
    if (int_onoff == INT_ON) begin
      m_irq = ld && (m_ecnt == int'(int_count));
      if (ld) m_ecnt = (m_ecnt == int'(int_count)) ? 0 : (m_ecnt + 1) % (1 << IW);
    end else begin
      m_irq = 0; m_ecnt = 0;
    end
    if (ld) begin
      m_P = int'(period); m_div = int'(div_clk); m_mode = int'(count_mode); m_mask = int'(mask_mode);
      m_wait = m_div;
      m_down = (m_mode == 0) ? 1'b0 : (m_mode == 1) ? 1'b1 : (m_pos != 0);
    end
    if (m_wait == 0) begin
      case (m_mode)
        1: begin m_pos = (m_pos == 0) ? m_P : m_pos - 1; m_down = 1; end
        2: begin
          if (m_P == 0) m_pos = 0;
          else m_pos = m_down ? m_pos - 1 : m_pos + 1;
          if (m_pos == 0) m_down = 0;
          else if (m_pos >= m_P) m_down = 1;
        end
        default: begin m_pos = (m_pos >= m_P) ? 0 : m_pos + 1; m_down = 0; end
      endcase
      m_fresh = 1; m_wait = m_div;
    end else begin
      m_fresh = 0; m_wait = m_wait - 1;
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_model();
    logic [22:0] act, exp;
    act = {carrier, dir_down, step, min_evt, max_evt, load_evt, irq};
    exp = {PW'(m_pos), m_down, m_fresh, m_min(), m_max(), m_load(), m_irq};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL model {carrier,dir,step,min,max,load,irq} @%0t: got %h expected %h", $time, act, exp);
    end
  endtask

  task automatic clk_cycle();
    @(posedge clk);
    if (rstn) model_edge(); else model_reset();
    #1;
    check_model();
  endtask

  task automatic apply(input bit on, input int mode, input int mask, input int dv, input int per, input int ini);
    pwm_onoff = on ? PWM_ON : PWM_OFF;
    count_mode = _count_mode'(mode);
    mask_mode = _mask_mode'(mask);
    div_clk = DW'(dv); period = PW'(per); init_carrier = PW'(ini);
  endtask

  typedef struct {
    bit on; int mode; int mask; int dv; int per; int ini;
    int c; bit s; bit mn; bit mx; bit ld; bit dn;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(bit on, int mode, int mask, int dv, int per, int ini,
                              int c, bit s, bit mn, bit mx, bit ld, bit dn);
    vec_t v;
    v.on = on; v.mode = mode; v.mask = mask; v.dv = dv; v.per = per; v.ini = ini;
    v.c = c; v.s = s; v.mn = mn; v.mx = mx; v.ld = ld; v.dn = dn;
    return v;
  endfunction

  initial begin
    int expc[7];
    bit expl[7];
    // UP P=4 div=0 NO_MASK
    tbl.push_back(mk(0,0,0,0,4,0, 0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,4,0, 1,1,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,4,0, 2,1,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,4,0, 3,1,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,4,0, 4,1,0,1,1,0));
    tbl.push_back(mk(1,0,0,0,4,0, 0,1,1,0,1,0));
    tbl.push_back(mk(1,0,0,0,4,0, 1,1,0,0,0,0));
    // UPDOWN P=3 div=1 MIN_MASK
    tbl.push_back(mk(0,2,1,1,3,0, 0,0,0,0,0,0));
    tbl.push_back(mk(1,2,1,1,3,0, 0,0,0,0,0,0));
    tbl.push_back(mk(1,2,1,1,3,0, 1,1,0,0,0,0));
    tbl.push_back(mk(1,2,1,1,3,0, 1,0,0,0,0,0));
    tbl.push_back(mk(1,2,1,1,3,0, 2,1,0,0,0,0));
    tbl.push_back(mk(1,2,1,1,3,0, 2,0,0,0,0,0));
    tbl.push_back(mk(1,2,1,1,3,0, 3,1,0,1,1,1));
    tbl.push_back(mk(1,2,1,1,3,0, 3,0,0,0,0,1));
    tbl.push_back(mk(1,2,1,1,3,0, 2,1,0,0,0,1));
    tbl.push_back(mk(1,2,1,1,3,0, 2,0,0,0,0,1));
    tbl.push_back(mk(1,2,1,1,3,0, 1,1,0,0,0,1));
    tbl.push_back(mk(1,2,1,1,3,0, 1,0,0,0,0,1));
    tbl.push_back(mk(1,2,1,1,3,0, 0,1,1,0,0,0));
    tbl.push_back(mk(1,2,1,1,3,0, 0,0,0,0,0,0));
    tbl.push_back(mk(1,2,1,1,3,0, 1,1,0,0,0,0));

    model_reset();
    #1;
    chk("reset carrier", int'(carrier), 0);
    chk("reset flags", int'({dir_down, step, min_evt, max_evt, load_evt, irq}), 0);
    clk_cycle();
    rstn = 1'b1;

    foreach (tbl[i]) begin
      apply(tbl[i].on, tbl[i].mode, tbl[i].mask, tbl[i].dv, tbl[i].per, tbl[i].ini);
      clk_cycle();
      chk($sformatf("tbl[%0d] carrier", i), int'(carrier), tbl[i].c);
      chk($sformatf("tbl[%0d] s/mn/mx/ld/dn", i), int'({step, min_evt, max_evt, load_evt, dir_down}),
          int'({tbl[i].s, tbl[i].mn, tbl[i].mx, tbl[i].ld, tbl[i].dn}));
    end

    // Period written mid-run under MIN_MASK takes effect only at the max event.
    apply(0, 0, 1, 0, 4, 0); clk_cycle();
    apply(1, 0, 1, 0, 4, 0); clk_cycle();
    chk("shadow start carrier", int'(carrier), 1);
    period = PW'(2);
    expc = '{2, 3, 4, 0, 1, 2, 0};
    expl = '{0, 0, 1, 0, 0, 1, 0};
    for (int k = 0; k < 7; k++) begin
      clk_cycle();
      chk($sformatf("shadow carrier[%0d]", k), int'(carrier), expc[k]);
      chk($sformatf("shadow load[%0d]", k), int'(load_evt), int'(expl[k]));
    end

    // IRQ decimation: every third load, one clock after it.
    apply(0, 0, 0, 0, 1, 0); int_onoff = INT_ON; int_count = IW'(2); clk_cycle();
    pwm_onoff = PWM_ON;
    for (int k = 1; k <= 10; k++) begin
      clk_cycle();
      chk($sformatf("irq[%0d]", k), int'(irq), int'(k > 1 && k % 3 == 1));
    end
    int_onoff = INT_OFF;

    // DOWN with clamped preload, then abort mid-run.
    apply(0, 1, 0, 0, 5, 7); clk_cycle();
    chk("down preload", int'(carrier), 5);
    chk("down preload dir", int'(dir_down), 1);
    pwm_onoff = PWM_ON;
    expc = '{4, 3, 2, 1, 0, 5, 4};
    for (int k = 0; k < 7; k++) begin
      clk_cycle();
      chk($sformatf("down carrier[%0d]", k), int'(carrier), expc[k]);
    end
    pwm_onoff = PWM_OFF; clk_cycle();
    chk("off abort carrier", int'(carrier), 5);
    chk("off abort events", int'({step, min_evt, max_evt, load_evt, irq}), 0);

    // Async reset mid-run, then P=0 straight out of reset.
    apply(1, 0, 0, 0, 4, 0);
    repeat (3) clk_cycle();
    #1 rstn = 1'b0;
    #1;
    model_reset();
    chk("async reset carrier", int'(carrier), 0);
    chk("async reset flags", int'({dir_down, step, min_evt, max_evt, load_evt, irq}), 0);
    repeat (2) clk_cycle();
    apply(1, 0, 0, 0, 0, 0);
    rstn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      clk_cycle();
      chk($sformatf("p0 min/max[%0d]", k), int'({min_evt, max_evt}), 2);
    end

    // Random configuration churn against the model.
    apply(0, 0, 0, 0, 3, 0);
    for (int n = 0; n < 3000; n++) begin
      if (pwm_onoff == PWM_OFF) begin
        if ($urandom_range(3) == 0) pwm_onoff = PWM_ON;
      end else if ($urandom_range(49) == 0) pwm_onoff = PWM_OFF;
      if ($urandom_range(7) == 0) count_mode = _count_mode'($urandom_range(2));
      if ($urandom_range(7) == 0) mask_mode = _mask_mode'($urandom_range(3));
      if ($urandom_range(7) == 0) period = PW'($urandom_range(6));
      if ($urandom_range(7) == 0) init_carrier = PW'($urandom_range(7));
      if ($urandom_range(7) == 0) div_clk = DW'($urandom_range(2));
      if ($urandom_range(7) == 0) int_onoff = $urandom_range(1) ? INT_ON : INT_OFF;
      if ($urandom_range(7) == 0) int_count = IW'($urandom_range(3));
      clk_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
